// File: rtl/apb_slave_if_pkg.sv
// Shared APB definitions: FSM state indices, one-hot state type and PPROT bit positions.
package apb_slave_if_pkg;

  localparam int STATE_IDLE = 0;
  localparam int STATE_REQ  = 1;
  localparam int STATE_RESP = 2;
  localparam int STATE_ERR  = 3;

  localparam int PROT_PRIV   = 0;
  localparam int PROT_NONSEC = 1;
  localparam int PROT_INSTR  = 2;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001 << STATE_IDLE,
    S_REQ  = 4'b0001 << STATE_REQ,
    S_RESP = 4'b0001 << STATE_RESP,
    S_ERR  = 4'b0001 << STATE_ERR
  } state_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB window decode: hit when the address is inside the window and
// aligned to the data bus width; offset is the address relative to the window base.
module apb_addr_decode #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WINDOW_SIZE = 4096
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] offset
);

  localparam int                    WIN_BITS   = $clog2(WINDOW_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  assign offset = addr - BASE_ADDR;

  // Addresses below the base wrap to a huge offset, so one upper-bit test bounds both ends.
  assign hit = (offset[ADDR_WIDTH-1:WIN_BITS] == '0) && ((addr & ALIGN_MASK) == '0);

endmodule

// File: rtl/apb_slave_if.sv
// APB completer: decodes a window and turns each transfer into a held request on the
// local port, inserting wait states until acknowledge, timeout or protocol error.
module apb_slave_if
  import apb_slave_if_pkg::*;
#(
  parameter int                        APB_DATA_WIDTH = 32,
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        WINDOW_SIZE    = 4096,
  parameter int                        TIMEOUT_CYCLE  = 6
) (
  input  logic                          apb_clk_in,
  input  logic                          apb_rst_in,
  input  logic [APB_ADDR_WIDTH-1:0]     apb_addr_in,
  input  logic                          apb_psel_in,
  input  logic                          apb_penable_in,
  input  logic                          apb_write_in,
  input  logic [APB_DATA_WIDTH-1:0]     apb_wdata_in,
  input  logic [APB_DATA_WIDTH/8-1:0]   apb_strb_in,
  input  logic [2:0]                    apb_prot_in,
  output logic [APB_DATA_WIDTH-1:0]     apb_rdata_out,
  output logic                          apb_ready_out,
  output logic                          apb_slverr_out,
  output logic [APB_ADDR_WIDTH-1:0]     other_addr_out,
  output logic                          other_sel_out,
  output logic                          other_write_out,
  output logic [APB_DATA_WIDTH-1:0]     other_wdata_out,
  output logic [APB_DATA_WIDTH/8-1:0]   other_strb_out,
  output logic [2:0]                    other_prot_out,
  input  logic [APB_DATA_WIDTH-1:0]     other_rdata_in,
  input  logic                          other_ready_in,
  input  logic                          other_error_in
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLE + 1);

  state_t                    state;
  logic [CNT_W-1:0]          wait_cnt;
  logic [APB_ADDR_WIDTH-1:0] lat_addr;
  logic                      err_wait_access;
  logic                      dec_hit;
  logic [APB_ADDR_WIDTH-1:0] dec_offset;

  apb_addr_decode #(
    .ADDR_WIDTH  (APB_ADDR_WIDTH),
    .DATA_WIDTH  (APB_DATA_WIDTH),
    .BASE_ADDR   (BASE_ADDR),
    .WINDOW_SIZE (WINDOW_SIZE)
  ) u_decode (
    .addr   (apb_addr_in),
    .hit    (dec_hit),
    .offset (dec_offset)
  );

  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      lat_addr        <= '0;
      err_wait_access <= 1'b0;
      apb_rdata_out   <= '0;
      apb_ready_out   <= 1'b0;
      apb_slverr_out  <= 1'b0;
      other_addr_out  <= '0;
      other_sel_out   <= 1'b0;
      other_write_out <= 1'b0;
      other_wdata_out <= '0;
      other_strb_out  <= '0;
      other_prot_out  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          apb_ready_out  <= 1'b0;
          apb_slverr_out <= 1'b0;
          apb_rdata_out  <= '0;
          if (apb_psel_in && !apb_penable_in) begin
            lat_addr                    <= apb_addr_in;
            other_addr_out              <= dec_offset;
            other_write_out             <= apb_write_in;
            other_wdata_out             <= apb_wdata_in;
            other_strb_out              <= apb_write_in ? apb_strb_in : '0;
            other_prot_out[PROT_PRIV]   <= apb_prot_in[PROT_PRIV];
            other_prot_out[PROT_NONSEC] <= apb_prot_in[PROT_NONSEC];
            other_prot_out[PROT_INSTR]  <= apb_prot_in[PROT_INSTR];
            if (dec_hit) begin
              state         <= S_REQ;
              other_sel_out <= 1'b1;
              wait_cnt      <= '0;
            end else begin
              state           <= S_ERR;
              apb_ready_out   <= 1'b1;
              apb_slverr_out  <= 1'b1;
              err_wait_access <= 1'b1;
            end
          end else if (apb_psel_in && apb_penable_in) begin
            state           <= S_ERR;
            apb_ready_out   <= 1'b1;
            apb_slverr_out  <= 1'b1;
            err_wait_access <= 1'b1;
          end
        end

        S_REQ: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!apb_psel_in) begin
            // Master abandoned the transfer: withdraw silently.
            other_sel_out <= 1'b0;
            state         <= S_IDLE;
          end else if (apb_addr_in != lat_addr || apb_write_in != other_write_out) begin
            other_sel_out   <= 1'b0;
            state           <= S_ERR;
            apb_ready_out   <= 1'b1;
            apb_slverr_out  <= 1'b1;
            err_wait_access <= 1'b0;
          end else if (other_ready_in) begin
            other_sel_out  <= 1'b0;
            apb_rdata_out  <= other_write_out ? '0 : other_rdata_in;
            apb_slverr_out <= other_error_in;
            apb_ready_out  <= 1'b1;
            state          <= S_RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLE - 1)) begin
            other_sel_out   <= 1'b0;
            state           <= S_ERR;
            apb_ready_out   <= 1'b1;
            apb_slverr_out  <= 1'b1;
            err_wait_access <= 1'b0;
          end
        end

        S_RESP: begin
          apb_ready_out  <= 1'b0;
          apb_slverr_out <= 1'b0;
          apb_rdata_out  <= '0;
          state          <= S_IDLE;
        end

        S_ERR: begin
          // A decode error raised at setup must stay visible until the access phase is seen.
          if (!err_wait_access || apb_penable_in || !apb_psel_in) begin
            apb_ready_out   <= 1'b0;
            apb_slverr_out  <= 1'b0;
            err_wait_access <= 1'b0;
            state           <= S_IDLE;
          end
        end

        default: begin
          state          <= S_IDLE;
          other_sel_out  <= 1'b0;
          apb_ready_out  <= 1'b0;
          apb_slverr_out <= 1'b0;
          apb_rdata_out  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_if.sv
// Bench for apb_slave_if: directed table, multi-cycle corner sequences and random transfers.
module tb_apb_slave_if;

  localparam logic [31:0] BASE = 32'h0002_0000;
  localparam int          WIN  = 4096;
  localparam int          TO   = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] oaddr, owdata, ordata;
  logic        osel, owrite, oready, oerror;
  logic [3:0]  ostrb;
  logic [2:0]  oprot;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          ack;      // request cycle in which the local side acks; 0 = never
    logic [31:0] lrdata;
    logic        lerr;
    int          e_rdy;    // cycle (setup = 1) in which PREADY is expected high
    logic        e_err;
    logic [31:0] e_rdata;
    int          e_sel;    // cycles other_sel_out is expected high
  } vec_t;

  typedef struct {
    int          rdy_cyc;
    logic        err;
    logic [31:0] rdata;
    int          sel;
    logic [31:0] oaddr;
    logic [31:0] owdata;
    logic [3:0]  ostrb;
    logic [2:0]  oprot;
    logic        owr;
  } obs_t;

  apb_slave_if #(
    .APB_DATA_WIDTH (32),
    .APB_ADDR_WIDTH (32),
    .BASE_ADDR      (BASE),
    .WINDOW_SIZE    (WIN),
    .TIMEOUT_CYCLE  (TO)
  ) dut (
    .apb_clk_in      (clk),
    .apb_rst_in      (rst),
    .apb_addr_in     (paddr),
    .apb_psel_in     (psel),
    .apb_penable_in  (penable),
    .apb_write_in    (pwrite),
    .apb_wdata_in    (pwdata),
    .apb_strb_in     (pstrb),
    .apb_prot_in     (pprot),
    .apb_rdata_out   (prdata),
    .apb_ready_out   (pready),
    .apb_slverr_out  (pslverr),
    .other_addr_out  (oaddr),
    .other_sel_out   (osel),
    .other_write_out (owrite),
    .other_wdata_out (owdata),
    .other_strb_out  (ostrb),
    .other_prot_out  (oprot),
    .other_rdata_in  (ordata),
    .other_ready_in  (oready),
    .other_error_in  (oerror)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected outcome of one transfer, from the protocol rules alone.
  function automatic vec_t model(vec_t v);
    vec_t        r;
    logic [31:0] off;
    r   = v;
    off = v.addr - BASE;
    if (v.addr < BASE || off >= WIN || v.addr[1:0] != 2'b00) begin
      r.e_rdy = 2; r.e_err = 1'b1; r.e_rdata = '0; r.e_sel = 0;
    end else if (v.ack >= 1 && v.ack <= TO) begin
      r.e_rdy = v.ack + 2; r.e_err = v.lerr; r.e_rdata = v.wr ? 32'h0 : v.lrdata; r.e_sel = v.ack;
    end else begin
      r.e_rdy = TO + 2; r.e_err = 1'b1; r.e_rdata = '0; r.e_sel = TO;
    end
    return r;
  endfunction

  // Runs one APB transfer with a local responder; leaves the bus in its completing access phase.
  task automatic xfer(input vec_t v, input string tag, output obs_t o);
    int cnt;
    o = '{default: 0};
    step();
    check({tag, ".prev_ready_low"}, pready, 1'b0);
    check({tag, ".prev_rdata_zero"}, prdata, 32'h0);
    psel = 1'b1; penable = 1'b0; paddr = v.addr; pwrite = v.wr;
    pwdata = v.wdata; pstrb = v.strb; pprot = v.prot;
    oready = 1'b0; oerror = 1'b0; ordata = v.lrdata;
    cnt = 0;
    for (int k = 2; k < 22; k++) begin
      step();
      penable = 1'b1;
      if (osel) begin
        cnt++;
        if (cnt == 1) begin
          o.oaddr = oaddr; o.owdata = owdata; o.ostrb = ostrb; o.oprot = oprot; o.owr = owrite;
        end
        oready = (v.ack != 0 && cnt == v.ack);
        oerror = oready & v.lerr;
      end else begin
        oready = 1'b0;
        oerror = 1'b0;
      end
      if (pready) begin
        o.rdy_cyc = k;
        o.err     = pslverr;
        o.rdata   = prdata;
        break;
      end
    end
    o.sel  = cnt;
    oready = 1'b0;
    oerror = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    obs_t o;
    xfer(v, tag, o);
    check({tag, ".ready_cycle"}, o.rdy_cyc, v.e_rdy);
    check({tag, ".slverr"}, o.err, v.e_err);
    check({tag, ".rdata"}, o.rdata, v.e_rdata);
    check({tag, ".sel_cycles"}, o.sel, v.e_sel);
    if (v.e_sel > 0) begin
      check({tag, ".other_addr"}, o.oaddr, v.addr - BASE);
      check({tag, ".other_wdata"}, o.owdata, v.wdata);
      check({tag, ".other_strb"}, o.ostrb, v.wr ? v.strb : 4'h0);
      check({tag, ".other_prot"}, o.oprot, v.prot);
      check({tag, ".other_write"}, o.owr, v.wr);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ready"}, pready, 1'b0);
    check({tag, ".slverr"}, pslverr, 1'b0);
    check({tag, ".rdata"}, prdata, 32'h0);
    check({tag, ".sel"}, osel, 1'b0);
    check({tag, ".oaddr"}, oaddr, 32'h0);
    check({tag, ".owdata"}, owdata, 32'h0);
    check({tag, ".ostrb"}, ostrb, 4'h0);
    check({tag, ".oprot"}, oprot, 3'h0);
    check({tag, ".owrite"}, owrite, 1'b0);
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; pprot = '0; ordata = '0; oready = 1'b0; oerror = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;

    //            addr          wr    wdata          strb  prot  ack lrdata         lerr  rdy err  rdata          sel
    tbl[0]  = '{BASE + 32'h10,  1'b1, 32'hDEADBEEF,  4'hF, 3'd0, 1,  32'h77777777,  1'b0, 3,  1'b0, 32'h0,         1};
    tbl[1]  = '{BASE + 32'h4,   1'b0, 32'h0,         4'hF, 3'd2, 3,  32'h12345678,  1'b0, 5,  1'b0, 32'h12345678,  3};
    tbl[2]  = '{BASE + 32'h1000,1'b0, 32'h0,         4'h0, 3'd0, 1,  32'h11111111,  1'b0, 2,  1'b1, 32'h0,         0};
    tbl[3]  = '{BASE + 32'h2,   1'b1, 32'hCCCC0000,  4'hF, 3'd0, 1,  32'h0,         1'b0, 2,  1'b1, 32'h0,         0};
    tbl[4]  = '{BASE + 32'h8,   1'b0, 32'h0,         4'h0, 3'd1, 0,  32'h99999999,  1'b0, 8,  1'b1, 32'h0,         6};
    tbl[5]  = '{BASE + 32'hC,   1'b1, 32'h01020304,  4'h3, 3'd0, 2,  32'h0,         1'b0, 4,  1'b0, 32'h0,         2};
    tbl[6]  = '{BASE + 32'h20,  1'b0, 32'h0,         4'h0, 3'd0, 1,  32'hA5A5A5A5,  1'b1, 3,  1'b1, 32'hA5A5A5A5,  1};
    tbl[7]  = '{BASE + 32'hFFC, 1'b0, 32'h0,         4'h0, 3'd7, 6,  32'hCAFE0001,  1'b0, 8,  1'b0, 32'hCAFE0001,  6};
    tbl[8]  = '{BASE - 32'h4,   1'b0, 32'h0,         4'h0, 3'd0, 1,  32'h22222222,  1'b0, 2,  1'b1, 32'h0,         0};
    tbl[9]  = '{BASE + 32'h40,  1'b1, 32'h55AA55AA,  4'hF, 3'd0, 7,  32'h0,         1'b0, 8,  1'b1, 32'h0,         6};
    tbl[10] = '{BASE + 32'h7F8, 1'b1, 32'h0BADF00D,  4'h5, 3'd5, 2,  32'hFFFFFFFF,  1'b0, 4,  1'b0, 32'h0,         2};
    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("t%0d", i));

    // psel withdrawn during the request: request falls, no PREADY pulse
    step();
    psel = 1'b1; penable = 1'b0; paddr = BASE + 32'h30; pwrite = 1'b0; oready = 1'b0;
    step();
    check("abort.sel_up", osel, 1'b1);
    penable = 1'b1;
    step();
    check("abort.still_waiting", pready, 1'b0);
    psel = 1'b0; penable = 1'b0;
    step();
    check("abort.sel_dropped", osel, 1'b0);
    check("abort.no_ready", pready, 1'b0);
    step();
    check("abort.no_ready_later", pready, 1'b0);
    check("abort.sel_stays_low", osel, 1'b0);

    // access phase with no setup phase
    psel = 1'b1; penable = 1'b1; paddr = BASE + 32'h10; pwrite = 1'b1;
    step();
    check("nosetup.ready", pready, 1'b1);
    check("nosetup.slverr", pslverr, 1'b1);
    check("nosetup.sel", osel, 1'b0);
    step();
    check("nosetup.ready_drop", pready, 1'b0);
    psel = 1'b0; penable = 1'b0;

    // address changed while the request is pending
    step();
    psel = 1'b1; penable = 1'b0; paddr = BASE + 32'h10; pwrite = 1'b1;
    step();
    check("mismatch.sel_up", osel, 1'b1);
    penable = 1'b1; paddr = BASE + 32'h14;
    step();
    check("mismatch.ready", pready, 1'b1);
    check("mismatch.slverr", pslverr, 1'b1);
    check("mismatch.sel", osel, 1'b0);
    psel = 1'b0; penable = 1'b0;
    step();
    check("mismatch.ready_drop", pready, 1'b0);

    // reset while a request is pending
    psel = 1'b1; penable = 1'b0; paddr = BASE + 32'h18; pwrite = 1'b1;
    pwdata = 32'h5555AAAA; pstrb = 4'hF; pprot = 3'd3;
    step();
    check("rst_req.sel_up", osel, 1'b1);
    penable = 1'b1; rst = 1'b1;
    step();
    check_all_zero("rst_req");
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    run_vec(model('{BASE + 32'h18, 1'b1, 32'h13579BDF, 4'hF, 3'd1, 2, 32'h0, 1'b0, 0, 1'b0, 32'h0, 0}), "post_rst");

    for (int i = 0; i < 40; i++) begin
      rv.addr = BASE - 32'd32 + 32'($urandom_range(0, (WIN + 64) / 4)) * 32'd4;
      if ($urandom_range(0, 7) == 0) rv.addr = rv.addr + 32'($urandom_range(1, 3));
      rv.wr     = 1'($urandom_range(0, 1));
      rv.wdata  = $urandom;
      rv.strb   = 4'($urandom_range(0, 15));
      rv.prot   = 3'($urandom_range(0, 7));
      rv.ack    = $urandom_range(0, 8);
      rv.lrdata = $urandom;
      rv.lerr   = ($urandom_range(0, 5) == 0);
      run_vec(model(rv), $sformatf("r%0d", i));
    end

    psel = 1'b0; penable = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
